rx_frame_filter: RTL and testbench

//  Parametrised frame filter/buffer between rx_receiver and the consuming logic.

---
 rtl/rx_frame_filter.sv | 161 ++++++++++++++++
 tb/tb_rx_frame_filter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_filter.sv
`default_nettype none
// ============================================================================
// Module      : rx_frame_filter
// Description : Classifies received frames, queues accepted ones in a FWFT
//               FIFO and keeps saturating statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_filter #(
    parameter int ID_W      = 2,
    parameter int PAYLOAD_W = 128,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 16,
    parameter int BCAST_EN  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ID_W-1:0]          my_id,
    input  logic                     promisc,
    input  logic                     cnt_clr,
    input  logic                     in_valid,
    input  logic                     in_crc_err,
    input  logic [ID_W-1:0]          in_dest,
    input  logic [ID_W-1:0]          in_src,
    input  logic [PAYLOAD_W-1:0]     in_payload,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ID_W-1:0]          out_dest,
    output logic [ID_W-1:0]          out_src,
    output logic [PAYLOAD_W-1:0]     out_payload,
    output logic                     out_bcast,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     invalid_pkt,
    output logic                     overflow,
    output logic [CNT_W-1:0]         ok_cnt,
    output logic [CNT_W-1:0]         crc_cnt,
    output logic [CNT_W-1:0]         miss_cnt,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int              c_AW       = $clog2(DEPTH);
    localparam int              c_LW       = c_AW + 1;
    localparam logic [ID_W-1:0] c_BCAST_ID = '1;
    localparam logic [c_LW-1:0] c_FULL_LVL = c_LW'(DEPTH);

    logic [ID_W-1:0]      r_mem_dest    [DEPTH];
    logic [ID_W-1:0]      r_mem_src     [DEPTH];
    logic [PAYLOAD_W-1:0] r_mem_payload [DEPTH];
    logic                 r_mem_bcast   [DEPTH];

    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_LW-1:0]  r_level;
    logic             r_invalid;
    logic             r_overflow;
    logic [CNT_W-1:0] r_ok_cnt;
    logic [CNT_W-1:0] r_crc_cnt;
    logic [CNT_W-1:0] r_miss_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    logic w_empty;
    logic w_full;
    logic w_is_bcast;
    logic w_match;
    logic w_good;
    logic w_accept;
    logic w_miss;
    logic w_crc;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Classification: CRC error outranks addressing; accepted frames may still be dropped when full.
    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == c_FULL_LVL);
    assign w_is_bcast = (BCAST_EN != 0) && (in_dest == c_BCAST_ID);
    assign w_match    = (in_dest == my_id) || w_is_bcast || promisc;
    assign w_good     = in_valid && !in_crc_err;
    assign w_crc      = in_valid && in_crc_err;
    assign w_accept   = w_good && w_match;
    assign w_miss     = w_good && !w_match;
    assign w_pop      = !w_empty && out_ready;
    assign w_push     = w_accept && (!w_full || w_pop);
    assign w_drop     = w_accept && !w_push;

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // Frame storage carries no reset; validity is tracked purely by the pointers and level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_dest[r_wr_ptr]    <= in_dest;
            r_mem_src[r_wr_ptr]     <= in_src;
            r_mem_payload[r_wr_ptr] <= in_payload;
            r_mem_bcast[r_wr_ptr]   <= w_is_bcast;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_invalid <= 1'b0;
        end else if (w_good) begin
            r_invalid <= !w_match;
        end
    end

    // Clear wins over any event arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_ok_cnt   <= '0;
            r_crc_cnt  <= '0;
            r_miss_cnt <= '0;
            r_drop_cnt <= '0;
        end else if (cnt_clr) begin
            r_overflow <= 1'b0;
            r_ok_cnt   <= '0;
            r_crc_cnt  <= '0;
            r_miss_cnt <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_drop) r_overflow <= 1'b1;
            r_ok_cnt   <= f_sat_inc(r_ok_cnt,   w_push);
            r_crc_cnt  <= f_sat_inc(r_crc_cnt,  w_crc);
            r_miss_cnt <= f_sat_inc(r_miss_cnt, w_miss);
            r_drop_cnt <= f_sat_inc(r_drop_cnt, w_drop);
        end
    end

    // Head fields are forced to zero while empty so reset leaves every output at 0.
    assign out_valid   = !w_empty;
    assign out_dest    = w_empty ? '0   : r_mem_dest[r_rd_ptr];
    assign out_src     = w_empty ? '0   : r_mem_src[r_rd_ptr];
    assign out_payload = w_empty ? '0   : r_mem_payload[r_rd_ptr];
    assign out_bcast   = w_empty ? 1'b0 : r_mem_bcast[r_rd_ptr];
    assign fifo_level  = r_level;
    assign invalid_pkt = r_invalid;
    assign overflow    = r_overflow;
    assign ok_cnt      = r_ok_cnt;
    assign crc_cnt     = r_crc_cnt;
    assign miss_cnt    = r_miss_cnt;
    assign drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_frame_filter
// Description : Directed, table-driven self-checking bench for rx_frame_filter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_frame_filter;

    localparam int ID_W      = 2;
    localparam int PAYLOAD_W = 128;
    localparam int DEPTH     = 4;
    localparam int CNT_W     = 4;

    logic                   clk;
    logic                   rst_n;
    logic [ID_W-1:0]        my_id;
    logic                   promisc;
    logic                   cnt_clr;
    logic                   in_valid;
    logic                   in_crc_err;
    logic [ID_W-1:0]        in_dest;
    logic [ID_W-1:0]        in_src;
    logic [PAYLOAD_W-1:0]   in_payload;
    logic                   out_valid;
    logic                   out_ready;
    logic [ID_W-1:0]        out_dest;
    logic [ID_W-1:0]        out_src;
    logic [PAYLOAD_W-1:0]   out_payload;
    logic                   out_bcast;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   invalid_pkt;
    logic                   overflow;
    logic [CNT_W-1:0]       ok_cnt;
    logic [CNT_W-1:0]       crc_cnt;
    logic [CNT_W-1:0]       miss_cnt;
    logic [CNT_W-1:0]       drop_cnt;

    int checks;
    int failures;

    rx_frame_filter #(
        .ID_W(ID_W), .PAYLOAD_W(PAYLOAD_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .BCAST_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .my_id(my_id), .promisc(promisc), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_crc_err(in_crc_err), .in_dest(in_dest), .in_src(in_src),
        .in_payload(in_payload), .out_valid(out_valid), .out_ready(out_ready),
        .out_dest(out_dest), .out_src(out_src), .out_payload(out_payload),
        .out_bcast(out_bcast), .fifo_level(fifo_level), .invalid_pkt(invalid_pkt),
        .overflow(overflow), .ok_cnt(ok_cnt), .crc_cnt(crc_cnt), .miss_cnt(miss_cnt),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic       crc;
        logic       prom;
        logic       rdy;
        logic [1:0] dest;
        logic [7:0] pay;
        logic       e_ov;
        logic [2:0] e_lvl;
        logic       e_inv;
        logic [3:0] e_ok;
        logic [3:0] e_crc;
        logic [3:0] e_miss;
        logic [3:0] e_drop;
        logic       e_ovf;
        logic [7:0] e_head;
        logic       e_bc;
    } vec_t;

    vec_t vt [16];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_crc_err = 1'b0;
        in_dest    = '0;
        in_src     = 2'd2;
        in_payload = '0;
        out_ready  = 1'b0;
        promisc    = 1'b0;
        cnt_clr    = 1'b0;
    endtask

    // One-cycle in_valid pulse; consecutive calls give back-to-back pulses.
    task automatic frame(input logic crc, input logic [1:0] dest, input logic [7:0] pay);
        in_valid   = 1'b1;
        in_crc_err = crc;
        in_dest    = dest;
        in_payload = {{(PAYLOAD_W-8){1'b0}}, pay};
        @(negedge clk);
        in_valid   = 1'b0;
        in_crc_err = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        my_id    = 2'd1;
        rst_n    = 1'b1;
        idle_inputs();
        // vld crc prom rdy dest pay | ov lvl inv ok crc miss drop ovf head bc
        vt[0]  = '{1'b1,1'b0,1'b0,1'b0,2'd1,8'hAB, 1'b1,3'd1,1'b0,4'd1,4'd0,4'd0,4'd0,1'b0,8'hAB,1'b0};
        vt[1]  = '{1'b1,1'b0,1'b0,1'b0,2'd2,8'h11, 1'b1,3'd1,1'b1,4'd1,4'd0,4'd1,4'd0,1'b0,8'hAB,1'b0};
        vt[2]  = '{1'b1,1'b0,1'b0,1'b0,2'd3,8'h33, 1'b1,3'd2,1'b0,4'd2,4'd0,4'd1,4'd0,1'b0,8'hAB,1'b0};
        vt[3]  = '{1'b1,1'b0,1'b0,1'b0,2'd2,8'h55, 1'b1,3'd2,1'b1,4'd2,4'd0,4'd2,4'd0,1'b0,8'hAB,1'b0};
        vt[4]  = '{1'b1,1'b1,1'b0,1'b0,2'd1,8'h44, 1'b1,3'd2,1'b1,4'd2,4'd1,4'd2,4'd0,1'b0,8'hAB,1'b0};
        vt[5]  = '{1'b1,1'b0,1'b1,1'b0,2'd2,8'h66, 1'b1,3'd3,1'b0,4'd3,4'd1,4'd2,4'd0,1'b0,8'hAB,1'b0};
        vt[6]  = '{1'b1,1'b0,1'b0,1'b0,2'd1,8'h77, 1'b1,3'd4,1'b0,4'd4,4'd1,4'd2,4'd0,1'b0,8'hAB,1'b0};
        vt[7]  = '{1'b1,1'b0,1'b0,1'b0,2'd1,8'h88, 1'b1,3'd4,1'b0,4'd4,4'd1,4'd2,4'd1,1'b1,8'hAB,1'b0};
        vt[8]  = '{1'b1,1'b0,1'b0,1'b1,2'd1,8'h99, 1'b1,3'd4,1'b0,4'd5,4'd1,4'd2,4'd1,1'b1,8'h33,1'b1};
        vt[9]  = '{1'b0,1'b0,1'b0,1'b1,2'd0,8'h00, 1'b1,3'd3,1'b0,4'd5,4'd1,4'd2,4'd1,1'b1,8'h66,1'b0};
        vt[10] = '{1'b0,1'b0,1'b0,1'b1,2'd0,8'h00, 1'b1,3'd2,1'b0,4'd5,4'd1,4'd2,4'd1,1'b1,8'h77,1'b0};
        vt[11] = '{1'b0,1'b0,1'b0,1'b1,2'd0,8'h00, 1'b1,3'd1,1'b0,4'd5,4'd1,4'd2,4'd1,1'b1,8'h99,1'b0};
        vt[12] = '{1'b0,1'b0,1'b0,1'b1,2'd0,8'h00, 1'b0,3'd0,1'b0,4'd5,4'd1,4'd2,4'd1,1'b1,8'h00,1'b0};
        vt[13] = '{1'b1,1'b0,1'b0,1'b1,2'd1,8'hAA, 1'b1,3'd1,1'b0,4'd6,4'd1,4'd2,4'd1,1'b1,8'hAA,1'b0};
        vt[14] = '{1'b1,1'b0,1'b0,1'b0,2'd1,8'hBB, 1'b1,3'd2,1'b0,4'd7,4'd1,4'd2,4'd1,1'b1,8'hAA,1'b0};
        vt[15] = '{1'b1,1'b0,1'b0,1'b0,2'd2,8'hCC, 1'b1,3'd2,1'b1,4'd7,4'd1,4'd3,4'd1,1'b1,8'hAA,1'b0};

        @(negedge clk);
        do_reset();
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_level", 128'(fifo_level), 128'(0));
        check("rst_ok_cnt", 128'(ok_cnt), 128'(0));
        check("rst_invalid", 128'(invalid_pkt), 128'(0));

        for (int i = 0; i < 16; i++) begin
            in_valid   = vt[i].vld;
            in_crc_err = vt[i].crc;
            promisc    = vt[i].prom;
            out_ready  = vt[i].rdy;
            in_dest    = vt[i].dest;
            in_payload = {{(PAYLOAD_W-8){1'b0}}, vt[i].pay};
            @(negedge clk);
            check($sformatf("v%0d_out_valid", i), 128'(out_valid), 128'(vt[i].e_ov));
            check($sformatf("v%0d_level", i), 128'(fifo_level), 128'(vt[i].e_lvl));
            check($sformatf("v%0d_invalid", i), 128'(invalid_pkt), 128'(vt[i].e_inv));
            check($sformatf("v%0d_ok_cnt", i), 128'(ok_cnt), 128'(vt[i].e_ok));
            check($sformatf("v%0d_crc_cnt", i), 128'(crc_cnt), 128'(vt[i].e_crc));
            check($sformatf("v%0d_miss_cnt", i), 128'(miss_cnt), 128'(vt[i].e_miss));
            check($sformatf("v%0d_drop_cnt", i), 128'(drop_cnt), 128'(vt[i].e_drop));
            check($sformatf("v%0d_overflow", i), 128'(overflow), 128'(vt[i].e_ovf));
            check($sformatf("v%0d_head", i), out_payload, {120'h0, vt[i].e_head});
            check($sformatf("v%0d_bcast", i), 128'(out_bcast), 128'(vt[i].e_bc));
        end
        check("head_src", 128'(out_src), 128'(2));
        check("head_dest", 128'(out_dest), 128'(1));
        idle_inputs();

        // Reset with three frames queued discards everything.
        frame(1'b0, 2'd1, 8'hDD);
        check("pre_rst_level", 128'(fifo_level), 128'(3));
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 128'(out_valid), 128'(0));
        check("async_rst_level", 128'(fifo_level), 128'(0));
        check("async_rst_counters", 128'({ok_cnt, crc_cnt, miss_cnt, drop_cnt}), 128'(0));
        check("async_rst_flags", 128'({overflow, invalid_pkt}), 128'(0));
        check("async_rst_payload", out_payload, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Six good frames into a depth-4 FIFO, then drain in order.
        for (int i = 1; i <= 6; i++) frame(1'b0, 2'd1, 8'(i));
        check("burst_level", 128'(fifo_level), 128'(4));
        check("burst_drop_cnt", 128'(drop_cnt), 128'(2));
        check("burst_overflow", 128'(overflow), 128'(1));
        check("burst_ok_cnt", 128'(ok_cnt), 128'(4));
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain_%0d", i), out_payload, 128'(i));
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("drained_valid", 128'(out_valid), 128'(0));
        check("drained_level", 128'(fifo_level), 128'(0));

        // Back-to-back CRC errors saturate the 4-bit counter.
        for (int i = 0; i < 20; i++) frame(1'b1, 2'd1, 8'h00);
        check("crc_saturate", 128'(crc_cnt), 128'(15));
        check("crc_no_push", 128'(fifo_level), 128'(0));

        // cnt_clr coincident with a miss: clear wins, FIFO and invalid_pkt untouched.
        frame(1'b0, 2'd1, 8'h5A);
        frame(1'b0, 2'd0, 8'h00);
        check("pre_clr_miss", 128'(miss_cnt), 128'(1));
        cnt_clr = 1'b1;
        frame(1'b0, 2'd2, 8'h00);
        cnt_clr = 1'b0;
        check("clr_miss_cnt", 128'(miss_cnt), 128'(0));
        check("clr_crc_cnt", 128'(crc_cnt), 128'(0));
        check("clr_overflow", 128'(overflow), 128'(0));
        check("clr_invalid_kept", 128'(invalid_pkt), 128'(1));
        check("clr_fifo_kept", 128'(fifo_level), 128'(1));
        check("clr_head_kept", out_payload, 128'(8'h5A));
        frame(1'b1, 2'd1, 8'h00);
        check("post_clr_crc", 128'(crc_cnt), 128'(1));
        check("crc_invalid_kept", 128'(invalid_pkt), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
